// File: rtl/d_pipe_reg_pkg.sv
// Shared defaults and the occupancy-counter width helper for the D-register pipeline.
package d_pipe_reg_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One pipeline stage: valid bit, data register and its advance/capture logic.
module d_pipe_stage
    import d_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ready
);

    logic take;

    // A stage can accept when it is empty or its word leaves this same cycle.
    assign ready = !valid || down_ready;
    assign take  = up_valid && ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else
                valid <= take || (valid && !down_ready);
            if (take)
                data <= up_data;
        end
    end

endmodule

// File: rtl/d_pipe_reg.sv
// Elastic D-register pipeline with bubble collapsing, flush and occupancy count.
module d_pipe_reg
    import d_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          D,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          Q,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] dat [DEPTH];

    // Ready ripples combinationally from out_ready back to stage 0.
    assign rdy[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = D;
        end else begin : g_body
            assign up_v = vld[k-1];
            assign up_d = dat[k-1];
        end

        d_pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .up_valid  (up_v),
            .up_data   (up_d),
            .down_ready(rdy[k+1]),
            .valid     (vld[k]),
            .data      (dat[k]),
            .ready     (rdy[k])
        );
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = vld[DEPTH-1];
    assign Q         = dat[DEPTH-1];

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            count = count + CW'(vld[i]);
    end

endmodule

// File: tb/tb_d_pipe_reg.sv
// Randomised and directed bench for d_pipe_reg with a word-position reference model and output scoreboard.
module tb_d_pipe_reg;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_d, a_q;
    logic [2:0] a_count;

    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_d, b_q;
    logic [0:0] b_count;

    int checks = 0;
    int errors = 0;

    // Reference model: each in-flight word with its stage position, oldest first.
    int         mpos[$];
    logic [7:0] mdat[$];
    int         np[$];
    logic [7:0] sb[$];
    int         exp_count;
    logic       exp_ov, exp_ir;
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

    d_pipe_reg #(.WIDTH(8), .DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .D(a_d),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .Q(a_q), .count(a_count)
    );

    d_pipe_reg #(.WIDTH(8), .DEPTH(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .D(b_d),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .Q(b_q), .count(b_count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected combinational outputs and next word positions for the current inputs.
    task automatic compute_exp();
        int lim;
        int p;
        lim       = DEPTH;
        exp_count = mpos.size();
        exp_ov    = (mpos.size() != 0) && (mpos[0] == DEPTH - 1);
        np.delete();
        foreach (mpos[i]) begin
            if (i == 0 && exp_ov && a_out_ready)
                p = DEPTH;
            else
                p = (mpos[i] + 1 < lim - 1) ? mpos[i] + 1 : lim - 1;
            np.push_back(p);
            lim = p;
        end
        exp_ir = !a_flush && (mpos.size() == 0 || lim > 0);
    endtask

    task automatic model_step();
        int         kp[$];
        logic [7:0] kd[$];
        if (a_flush) begin
            mpos.delete();
            mdat.delete();
            sb.delete();
        end else begin
            foreach (np[i])
                if (np[i] < DEPTH) begin
                    kp.push_back(np[i]);
                    kd.push_back(mdat[i]);
                end
            if (a_in_valid && exp_ir) begin
                kp.push_back(0);
                kd.push_back(a_d);
                sb.push_back(a_d);
            end
            mpos = kp;
            mdat = kd;
        end
    endtask

    task automatic apply(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        a_in_valid  = v;
        a_d         = d;
        a_out_ready = ordy;
        a_flush     = fl;
        compute_exp();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #2;
        a_flush = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_q", a_q, 0);
        chk("rst_count", a_count, 0);
        chk("rst_in_ready", a_in_ready, 1);
        mpos.delete();
        mdat.delete();
        sb.delete();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        compute_exp();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: compares handshake/count every cycle and pops the scoreboard on each output transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                chk("a_count", a_count, exp_count);
                chk("a_out_valid", a_out_valid, exp_ov);
                chk("a_in_ready", a_in_ready, exp_ir);
                if (a_out_valid && a_out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_q: got %0h with no word expected at %0t", a_q, $time);
                    end else begin
                        chk("a_q", a_q, sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] bq[$];
        logic       bv;
        rst_n = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_d = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_d = '0; b_out_ready = 1'b0;
        @(posedge clk);
        #3;
        chk("init_out_valid", a_out_valid, 0);
        chk("init_count", a_count, 0);
        chk("init_in_ready", a_in_ready, 1);
        rst_n = 1'b1;
        compute_exp();
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Streaming
        for (int i = 1; i <= 8; i++) apply(1'b1, 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Backpressure: fill, hold while full, then release
        for (int i = 0; i < 4; i++) apply(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Bubble collapse
        apply(1'b1, 8'h11, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush with a coincident output transfer
        apply(1'b1, 8'h31, 1'b0, 1'b0);
        apply(1'b1, 8'h32, 1'b0, 1'b0);
        apply(1'b1, 8'h33, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 8'h55, 1'b1, 1'b1);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset with the pipeline full
        for (int i = 0; i < 5; i++) apply(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        do_reset();
        apply(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++)
            apply(1'($urandom_range(0, 99) < 70), 8'($urandom),
                  1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 4));
        for (int i = 0; i < DEPTH + 2; i++) apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk("a_drain_empty", a_count, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL a_sb_empty: got %0d words outstanding expected 0", sb.size());
        end
        mon_en = 1'b0;

        // DEPTH=1 slice: continuous in_valid, alternating out_ready
        for (int i = 0; i < 40; i++) begin
            b_in_valid  = 1'b1;
            b_d         = 8'($urandom);
            b_out_ready = (i % 2 == 0);
            #4;
            bv = (bq.size() != 0);
            chk("b_out_valid", b_out_valid, bv);
            chk("b_in_ready", b_in_ready, !bv || b_out_ready);
            chk("b_count", b_count, bq.size());
            if (bv) chk("b_q", b_q, bq[0]);
            @(posedge clk);
            if (bv && b_out_ready) void'(bq.pop_front());
            if (!bv || b_out_ready) bq.push_back(b_d);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
